mavg_sample_arbiter: RTL and testbench

//   Shares one moving-average filter between NUM_CH sample sources.
//   - Round-robin grants among the requesting channels.
//   - Drives the filter strobe/data pair, waits for the filter's done pulse, and captures the average.
//   - Returns the average tagged with the channel index.
//   - Sits between the per-channel sample sources and the filter core.

---
 rtl/mavg_sample_arbiter_if.sv | 31 +++
 rtl/mavg_sample_arbiter.sv | 123 ++++++++++++
 tb/tb_mavg_sample_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mavg_sample_arbiter_if.sv
// rtl/mavg_sample_arbiter_if.sv - sample-source, filter and result signals of the moving-average arbiter
// master: arbiter side; slave: sources/filter/result-consumer side.
interface mavg_sample_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 10
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        req_i;
  logic [NUM_CH*DATA_W-1:0] data_i;
  logic [NUM_CH-1:0]        ack_o;
  logic                     filt_strobe_o;
  logic [DATA_W-1:0]        filt_data_o;
  logic                     filt_done_i;
  logic [DATA_W-1:0]        filt_avg_i;
  logic                     res_valid_o;
  logic [CH_W-1:0]          res_ch_o;
  logic [DATA_W-1:0]        res_data_o;
  logic                     busy_o;
  logic                     err_o;

  modport master (
    input  req_i, data_i, filt_done_i, filt_avg_i,
    output ack_o, filt_strobe_o, filt_data_o, res_valid_o, res_ch_o, res_data_o, busy_o, err_o
  );

  modport slave (
    output req_i, data_i, filt_done_i, filt_avg_i,
    input  ack_o, filt_strobe_o, filt_data_o, res_valid_o, res_ch_o, res_data_o, busy_o, err_o
  );
endinterface

// File: rtl/mavg_sample_arbiter.sv
// rtl/mavg_sample_arbiter.sv - round-robin sharing of one moving-average filter among NUM_CH sources
// Optional WAIT_DONE abort counter enabled by `define MAVG_TIMEOUT_EN.
module mavg_sample_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 10,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                   clk,
  input logic                   reset,
  mavg_sample_arbiter_if.master bus
);
  localparam int CH_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("mavg_sample_arbiter: NUM_CH and TIMEOUT_CYC must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, CAPTURE} state_t;

  state_t            state, state_nx;
  logic [CH_W-1:0]   rr_ptr, cur_ch, win_ch;
  logic              any_req, timeout_hit;
  logic              strobe_nx, res_valid_nx, busy_nx, err_nx;
  logic [NUM_CH-1:0] ack_nx;

  assign any_req = |bus.req_i;

  // Scan downwards so the channel closest after the pointer is written last and wins.
  always_comb begin
    win_ch = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (bus.req_i[CH_W'((int'(rr_ptr) + i) % NUM_CH)]) begin
        win_ch = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      end
    end
  end

`ifdef MAVG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state != WAIT_DONE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Abort decided one cycle early so the registered err_o lands TIMEOUT_CYC cycles after ISSUE.
  assign timeout_hit = (state == WAIT_DONE) && !bus.filt_done_i &&
                       (to_cnt == TO_W'(TIMEOUT_CYC - 2));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (any_req) state_nx = ISSUE;
      ISSUE:     state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.filt_done_i) begin
          state_nx = CAPTURE;
        end else if (timeout_hit) begin
          state_nx = IDLE;
        end
      end
      CAPTURE:   state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    strobe_nx    = (state == IDLE) && any_req;
    ack_nx       = '0;
    if (strobe_nx) ack_nx[win_ch] = 1'b1;
    res_valid_nx = (state == CAPTURE);
    err_nx       = timeout_hit;
    busy_nx      = (state_nx != IDLE);
  end

  // The filter re-reads filt_data_o during its AVERAGE cycle, so it only moves on a new grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr            <= CH_W'(NUM_CH - 1);
      cur_ch            <= '0;
      bus.filt_data_o   <= '0;
      bus.filt_strobe_o <= 1'b0;
      bus.ack_o         <= '0;
      bus.res_valid_o   <= 1'b0;
      bus.res_ch_o      <= '0;
      bus.res_data_o    <= '0;
      bus.busy_o        <= 1'b0;
      bus.err_o         <= 1'b0;
    end else begin
      bus.filt_strobe_o <= strobe_nx;
      bus.ack_o         <= ack_nx;
      bus.res_valid_o   <= res_valid_nx;
      bus.busy_o        <= busy_nx;
      bus.err_o         <= err_nx;
      if (strobe_nx) begin
        cur_ch          <= win_ch;
        bus.filt_data_o <= bus.data_i[int'(win_ch)*DATA_W +: DATA_W];
      end
      if (state == ISSUE) rr_ptr <= cur_ch;
      if (state == CAPTURE) begin
        bus.res_data_o <= bus.filt_avg_i;
        bus.res_ch_o   <= cur_ch;
      end
    end
  end
endmodule

// File: tb/tb_mavg_sample_arbiter.sv
// tb/tb_mavg_sample_arbiter.sv - randomized and directed bench for mavg_sample_arbiter against a timeline model
module tb_mavg_sample_arbiter;
  localparam int NUM_CH      = 4;
  localparam int DATA_W      = 10;
  localparam int TIMEOUT_CYC = 64;
  localparam int FILT_LAT    = 17;
`ifdef MAVG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mavg_sample_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  mavg_sample_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: transaction timeline (grant cycle, done cycle) rather than a state machine.
  bit                m_idle;
  int                m_ptr, m_ch, m_issue, m_done_at;
  logic              e_strobe, e_valid, e_busy, e_err;
  logic [NUM_CH-1:0] e_ack;
  logic [DATA_W-1:0] e_data, e_rdata;
  int                e_rch;

  logic [NUM_CH-1:0]        nxt_req = '0;
  logic [NUM_CH*DATA_W-1:0] nxt_data = '0;
  bit filt_en = 1, rand_en = 0, rand_data = 0, force_done = 0, force_spur_issue = 0, avg_fixed_en = 0;
  int spur_rate = 0;
  logic [DATA_W-1:0] avg_fixed = '0;
  int done_q[$];
  int grant_log[$];
  int n_strobe = 0, n_valid = 0, n_err = 0;
  int last_strobe_cyc = 0, last_valid_cyc = 0, last_err_cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; m_ptr = NUM_CH - 1; m_ch = 0; m_issue = 0; m_done_at = -1;
    e_strobe = 0; e_valid = 0; e_busy = 0; e_err = 0; e_ack = '0;
    e_data = '0; e_rdata = '0; e_rch = 0;
  endtask

  // Given the inputs applied in cycle cyc, derive what the registered outputs show in cycle cyc+1.
  task automatic model_step();
    int c;
    int w;
    bit found;
    c = cyc;
    e_strobe = 0; e_ack = '0; e_valid = 0; e_err = 0;
    if (m_idle) begin
      found = 0; w = 0;
      for (int i = 1; i <= NUM_CH; i++) begin
        if (!found && bus.req_i[(m_ptr + i) % NUM_CH]) begin
          w = (m_ptr + i) % NUM_CH;
          found = 1;
        end
      end
      if (found) begin
        m_ptr = w; m_ch = w;
        e_strobe = 1;
        e_ack = NUM_CH'(1) << w;
        e_data = bus.data_i[w*DATA_W +: DATA_W];
        m_idle = 0; m_issue = c + 1; m_done_at = -1;
      end
    end else if (m_done_at < 0) begin
      if (c > m_issue && bus.filt_done_i) begin
        m_done_at = c;
      end else if (TO_EN && c == m_issue + TIMEOUT_CYC - 1) begin
        e_err = 1; m_idle = 1;
      end
    end else if (c == m_done_at + 1) begin
      e_valid = 1; e_rdata = bus.filt_avg_i; e_rch = m_ch; m_idle = 1;
    end
    e_busy = !m_idle;
  endtask

  task automatic compare_all();
    chk("strobe", bus.filt_strobe_o, e_strobe);
    chk("ack", bus.ack_o, e_ack);
    chk("filt_data", bus.filt_data_o, e_data);
    chk("res_valid", bus.res_valid_o, e_valid);
    chk("res_ch", bus.res_ch_o, e_rch);
    chk("res_data", bus.res_data_o, e_rdata);
    chk("busy", bus.busy_o, e_busy);
    chk("err", bus.err_o, e_err);
  endtask

  task automatic rand_stim();
    for (int k = 0; k < NUM_CH; k++) begin
      if (nxt_req[k]) begin
        if (bus.ack_o[k] === 1'b1) nxt_req[k] = ($urandom_range(1) == 1);
        else if ($urandom_range(63) == 0) nxt_req[k] = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        nxt_req[k] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    bit done;
    @(posedge clk);
    #1;
    compare_all();
    if (bus.filt_strobe_o === 1'b1) begin
      n_strobe++; last_strobe_cyc = cyc;
      if (filt_en) done_q.push_back(cyc + FILT_LAT);
    end
    if (bus.res_valid_o === 1'b1) begin n_valid++; last_valid_cyc = cyc; end
    if (bus.err_o === 1'b1) begin n_err++; last_err_cyc = cyc; end
    for (int k = 0; k < NUM_CH; k++) if (bus.ack_o[k] === 1'b1) grant_log.push_back(k);
    done = 0;
    foreach (done_q[i]) if (done_q[i] == cyc) done = 1;
    while (done_q.size() > 0 && done_q[0] <= cyc) void'(done_q.pop_front());
    if (spur_rate != 0 && $urandom_range(spur_rate - 1) == 0) done = 1;
    if (force_done) done = 1;
    if (force_spur_issue && bus.filt_strobe_o === 1'b1) done = 1;
    if (rand_en) rand_stim();
    if (rand_data) for (int k = 0; k < NUM_CH; k++) nxt_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    bus.req_i       = nxt_req;
    bus.data_i      = nxt_data;
    bus.filt_done_i = done;
    bus.filt_avg_i  = avg_fixed_en ? avg_fixed : DATA_W'($urandom);
    model_step();
  endtask

  task automatic mid_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_strobe", bus.filt_strobe_o, 0);
    chk("rst_ack", bus.ack_o, 0);
    chk("rst_filt_data", bus.filt_data_o, 0);
    chk("rst_res_valid", bus.res_valid_o, 0);
    chk("rst_res_ch", bus.res_ch_o, 0);
    chk("rst_res_data", bus.res_data_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_err", bus.err_o, 0);
    done_q.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.req_i = nxt_req; bus.data_i = nxt_data; bus.filt_done_i = 1'b0; bus.filt_avg_i = '0;
    model_step();
  endtask

  task automatic wait_grant(input string name, input int budget);
    int g0, n;
    g0 = grant_log.size(); n = 0;
    while (grant_log.size() == g0 && n < budget) begin tick(); n++; end
    chk(name, grant_log.size(), g0 + 1);
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!m_idle && n < budget) begin tick(); n++; end
    tick();
    chk(name, bus.busy_o, 0);
  endtask

  initial begin
    int v0, e0, s, n;
    int exp2[5] = '{0, 1, 2, 3, 0};
    bus.req_i = '0; bus.data_i = '0; bus.filt_done_i = 1'b0; bus.filt_avg_i = '0;
    model_reset();
    mid_reset();

    // Round-robin from reset with all channels requesting.
    grant_log.delete(); n_strobe = 0; n_valid = 0;
    nxt_req = 4'b1111; n = 0;
    while (grant_log.size() < 5 && n < 400) begin
      tick(); n++;
      if (grant_log.size() >= 5) nxt_req = '0;
    end
    run_until_idle("t2_drain", 100);
    chk("t2_ngrant", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("t2_order", grant_log[i], exp2[i]);
    chk("t2_nstrobe", n_strobe, 5);
    chk("t2_nvalid", n_valid, 5);

    // Single request, fixed average; data churns after ISSUE.
    nxt_req = 4'b0100; nxt_data = '0; nxt_data[2*DATA_W +: DATA_W] = 10'h155;
    avg_fixed_en = 1; avg_fixed = 10'h0AB;
    wait_grant("t1_grant", 20);
    chk("t1_ack", bus.ack_o, 4'b0100);
    chk("t1_filt_data", bus.filt_data_o, 10'h155);
    nxt_req = '0; rand_data = 1;
    v0 = n_valid; n = 0;
    while (n_valid == v0 && n < 60) begin tick(); n++; end
    chk("t1_res_ch", bus.res_ch_o, 2);
    chk("t1_res_data", bus.res_data_o, 10'h0AB);
    chk("t3_filt_data_held", bus.filt_data_o, 10'h155);
    rand_data = 0; avg_fixed_en = 0;
    run_until_idle("t1_drain", 20);

    // Spurious done in IDLE, then in ISSUE.
    v0 = n_valid; force_done = 1;
    repeat (5) tick();
    force_done = 0;
    chk("t4_idle_busy", bus.busy_o, 0);
    chk("t4_idle_nvalid", n_valid, v0);
    force_spur_issue = 1; nxt_req = 4'b0001;
    wait_grant("t4_grant", 20);
    force_spur_issue = 0; nxt_req = '0;
    run_until_idle("t4_drain", 60);
    chk("t4_nvalid", n_valid, v0 + 1);
    chk("t4_latency", last_valid_cyc - last_strobe_cyc, FILT_LAT + 2);

    // Filter never answers.
    filt_en = 0; nxt_req = 4'b0001;
    wait_grant("t5_grant", 20);
    nxt_req = '0; s = last_strobe_cyc; v0 = n_valid; e0 = n_err;
`ifdef MAVG_TIMEOUT_EN
    n = 0;
    while (n_err == e0 && n < 120) begin tick(); n++; end
    chk("t5_nerr", n_err, e0 + 1);
    chk("t5_err_delay", last_err_cyc - s, TIMEOUT_CYC);
    tick();
    chk("t5_idle_after", bus.busy_o, 0);
    chk("t5_nvalid", n_valid, v0);
`else
    repeat (100) tick();
    chk("t5_busy_stuck", bus.busy_o, 1);
    chk("t5_no_err", n_err, e0);
    chk("t5_nvalid", n_valid, v0);
`endif

    // Reset in the middle of WAIT_DONE.
    nxt_req = 4'b0010;
    repeat (30) tick();
    chk("t6_busy_before", bus.busy_o, 1);
    filt_en = 1; nxt_req = 4'b1001;
    mid_reset();
    wait_grant("t6_grant", 20);
    chk("t6_first", grant_log[grant_log.size()-1], 0);
    nxt_req = '0;
    run_until_idle("t6_drain", 60);

    // Randomized traffic with spurious done pulses.
    rand_en = 1; rand_data = 1; spur_rate = 32;
    repeat (3000) tick();
    rand_en = 0; spur_rate = 0; nxt_req = '0;
    run_until_idle("rand_drain", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
